// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the RV32I datapath and the word-only dmem.
// Accepts one request at a time, checks it for illegal funct3 and misalignment,
// extracts and extends load data, and performs SB/SH as read-modify-write
// because dmem has no byte enables.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we, req_funct3  store flag and RV32I size/sign code
//   req_addr, req_wdata byte address and LSB-aligned store data
//   resp_valid          one-cycle response pulse
//   resp_rdata          extended load data (0 for stores and faults)
//   resp_misaligned     misaligned access flag, valid with resp_valid
//   resp_illegal        illegal access flag, valid with resp_valid
//   mem_read/mem_write  dmem strobes
//   mem_addr            word-aligned dmem address
//   mem_wdata           dmem write data
//   mem_rdata           dmem combinational read data
module dmem_lsu #(
  parameter bit RMW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t      state_r;
  logic [2:0]  funct3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        req_ready_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_misaligned_r;
  logic        resp_illegal_r;
  logic        mem_read_r;
  logic        mem_write_r;
  logic [31:0] mem_wdata_r;
  logic        illegal_s;
  logic        misaligned_s;

  // Pick the addressed byte/halfword out of a word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b010:  res = word;
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Merge new store data into the old word at the addressed lane (little-endian).
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [31:0] merged;
    merged = word;
    case (funct3)
      3'b000:  merged[{lane, 3'b000} +: 8] = data[7:0];
      3'b001:  merged[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: merged = data;
    endcase
    return merged;
  endfunction

  // Fault decode of the incoming request; illegal masks misaligned.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001: illegal_s = ~RMW_EN;
        3'b010:         illegal_s = 1'b0;
        default:        illegal_s = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
        default:                                illegal_s = 1'b1;
      endcase
    end
    if (illegal_s) begin
      misaligned_s = 1'b0;
    end else if (req_funct3[1:0] == 2'b01) begin
      misaligned_s = req_addr[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned_s = (req_addr[1:0] != 2'b00);
    end else begin
      misaligned_s = 1'b0;
    end
  end

  // Request FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      funct3_r          <= 3'd0;
      addr_r            <= 32'd0;
      wdata_r           <= 32'd0;
      req_ready_r       <= 1'b1;
      resp_valid_r      <= 1'b0;
      resp_rdata_r      <= 32'd0;
      resp_misaligned_r <= 1'b0;
      resp_illegal_r    <= 1'b0;
      mem_read_r        <= 1'b0;
      mem_write_r       <= 1'b0;
      mem_wdata_r       <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            funct3_r     <= req_funct3;
            addr_r       <= req_addr;
            wdata_r      <= req_wdata;
            req_ready_r  <= 1'b0;
            resp_rdata_r <= 32'd0;
            if (illegal_s || misaligned_s) begin
              state_r           <= ST_RESP;
              resp_valid_r      <= 1'b1;
              resp_illegal_r    <= illegal_s;
              resp_misaligned_r <= misaligned_s;
            end else if (!req_we) begin
              state_r    <= ST_LOAD;
              mem_read_r <= 1'b1;
            end else if (req_funct3 == 3'b010) begin
              state_r     <= ST_WRITE;
              mem_write_r <= 1'b1;
              mem_wdata_r <= req_wdata;
            end else begin
              state_r    <= ST_RMW_RD;
              mem_read_r <= 1'b1;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_r      <= ST_RESP;
          mem_read_r   <= 1'b0;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= load_extract(mem_rdata, funct3_r, addr_r[1:0]);
        end
        ST_RMW_RD: begin
          state_r     <= ST_WRITE;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b1;
          mem_wdata_r <= store_merge(mem_rdata, wdata_r, funct3_r, addr_r[1:0]);
        end
        ST_WRITE: begin
          state_r      <= ST_RESP;
          mem_write_r  <= 1'b0;
          mem_wdata_r  <= 32'd0;
          resp_valid_r <= 1'b1;
        end
        ST_RESP: begin
          state_r           <= ST_IDLE;
          req_ready_r       <= 1'b1;
          resp_valid_r      <= 1'b0;
          resp_rdata_r      <= 32'd0;
          resp_misaligned_r <= 1'b0;
          resp_illegal_r    <= 1'b0;
        end
        default: begin
          state_r           <= ST_IDLE;
          req_ready_r       <= 1'b1;
          resp_valid_r      <= 1'b0;
          resp_rdata_r      <= 32'd0;
          resp_misaligned_r <= 1'b0;
          resp_illegal_r    <= 1'b0;
          mem_read_r        <= 1'b0;
          mem_write_r       <= 1'b0;
          mem_wdata_r       <= 32'd0;
        end
      endcase
    end
  end

  assign req_ready       = req_ready_r;
  assign resp_valid      = resp_valid_r;
  assign resp_rdata      = resp_rdata_r;
  assign resp_misaligned = resp_misaligned_r;
  assign resp_illegal    = resp_illegal_r;
  assign mem_read        = mem_read_r;
  assign mem_write       = mem_write_r;
  assign mem_addr        = {addr_r[31:2], 2'b00};
  assign mem_wdata       = mem_wdata_r;

endmodule
